// File: rtl/csa_accumulator.sv
// Purpose: multi-operand accumulator; folds operand beats into a carry-save pair, then resolves to binary.
// Latency: result valid N+1 cycles after the last beat is accepted (N = ceil(WIDTH/CHUNK)).
// Backpressure: in_ready low while resolving or holding a result; result held until out_ready.
module csa_accumulator #(
    parameter int WIDTH = 13,
    parameter int CHUNK = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);

    // Number of carry-propagate chunks, padded width, and chunk index width.
    localparam int N     = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PW    = N * CHUNK;
    localparam int IDX_W = $clog2(N + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic [WIDTH-1:0]  c_q, c_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              rcarry_q, rcarry_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;

    logic              beat;
    logic [WIDTH-1:0]  cs;
    logic [PW-1:0]     s_pad;
    logic [PW-1:0]     cs_pad;
    logic [CHUNK:0]    chunk_sum;
    int unsigned       chunk_base;

    assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = out_data_q;
    assign out_count = count_q;

    // Next-state, carry-save fold, and chunked carry-propagate resolution.
    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        c_d        = c_q;
        count_d    = count_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        rcarry_d   = rcarry_q;
        out_data_d = out_data_q;

        beat = in_valid && in_ready;
        // Carry register holds carries at their generating bit; weight is one position up.
        cs     = {c_q[WIDTH-2:0], 1'b0};
        s_pad  = PW'(s_q);
        cs_pad = PW'(cs);
        chunk_base = (idx_q < LAST_IDX) ? (int'(idx_q) * CHUNK) : 0;
        chunk_sum  = {1'b0, s_pad[chunk_base +: CHUNK]}
                   + {1'b0, cs_pad[chunk_base +: CHUNK]}
                   + (CHUNK + 1)'(rcarry_q);

        case (state_q)
            ST_IDLE: begin
                if (beat) begin
                    s_d      = in_data;
                    c_d      = '0;
                    count_d  = CNT_W'(1);
                    idx_d    = '0;
                    rcarry_d = 1'b0;
                    state_d  = in_last ? ST_RESOLVE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (beat) begin
                    s_d     = s_q ^ cs ^ in_data;
                    c_d     = (s_q & cs) | (s_q & in_data) | (cs & in_data);
                    count_d = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
                    if (in_last) begin
                        idx_d    = '0;
                        rcarry_d = 1'b0;
                        state_d  = ST_RESOLVE;
                    end
                end
            end
            ST_RESOLVE: begin
                if (idx_q == LAST_IDX) begin
                    // All chunks resolved: publish, carry-out beyond WIDTH is discarded.
                    out_data_d = acc_q[WIDTH-1:0];
                    state_d    = ST_DONE;
                end else begin
                    acc_d[chunk_base +: CHUNK] = chunk_sum[CHUNK-1:0];
                    rcarry_d = chunk_sum[CHUNK];
                    idx_d    = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            c_q        <= '0;
            count_q    <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            rcarry_q   <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            c_q        <= c_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            rcarry_q   <= rcarry_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: tb/tb_csa_accumulator.sv
// Purpose: directed and exhaustive-small checks of csa_accumulator.
// Latency: expects result 5 cycles after last beat (WIDTH=13, CHUNK=4).
// Backpressure: exercises held results, bubbles and reset during resolution.
module tb_csa_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_data;
    logic [7:0]  out_count;
    logic        busy;

    int checks;
    int errors;

    logic [12:0] beat_q[$];
    bit          bubbles_en;

    csa_accumulator #(.WIDTH(13), .CHUNK(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer one beat starting at a negedge; returns at the negedge after acceptance.
    task automatic drive_beat(input logic [12:0] d, input bit l, output bit ok);
        int waited;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        ok       = 1'b0;
        waited   = 0;
        while (!ok && waited < 50) begin
            if (in_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end else begin
                @(negedge clk);
                waited++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Send beat_q (last flagged on final entry), wait for the result, optionally acknowledge.
    task automatic accumulate(input bit do_ack, output logic [12:0] res, output logic [7:0] cnt,
                              output int lat, output bit ok);
        bit a;
        ok = 1'b1;
        for (int i = 0; i < beat_q.size(); i++) begin
            if (bubbles_en) repeat ($urandom_range(0, 1)) @(negedge clk);
            drive_beat(beat_q[i], (i == beat_q.size() - 1), a);
            if (!a) ok = 1'b0;
        end
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) ok = 1'b0;
        res = out_data;
        cnt = out_count;
        if (do_ack) begin
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 13'd0 || out_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b busy=%b data=%h count=%0d, want 0/0/0/0",
                     out_valid, busy, out_data, out_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_single_beat();
        logic [12:0] r; logic [7:0] c; int lat; bit ok;
        beat_q = '{13'h1ABC};
        accumulate(1'b1, r, c, lat, ok);
        checks++;
        if (!ok || r !== 13'h1ABC || c !== 8'd1) begin
            errors++;
            $display("FAIL single_beat: ok=%b data=%h count=%0d, want 1ABC count 1", ok, r, c);
        end
        checks++;
        if (lat != 5) begin
            errors++;
            $display("FAIL single_latency: got %0d want 5", lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] r; logic [7:0] c; int lat; bit ok;
        beat_q = '{13'd5, 13'd7, 13'd9};
        accumulate(1'b1, r, c, lat, ok);
        checks++;
        if (!ok || r !== 13'd21 || c !== 8'd3 || lat != 5) begin
            errors++;
            $display("FAIL back_to_back: ok=%b data=%0d count=%0d lat=%0d, want 21/3/5", ok, r, c, lat);
        end
        beat_q = '{13'h1FFF, 13'h1FFF, 13'h1FFF};
        accumulate(1'b1, r, c, lat, ok);
        checks++;
        if (!ok || r !== 13'h1FFD || c !== 8'd3) begin
            errors++;
            $display("FAIL carry_heavy: ok=%b data=%h count=%0d, want 1FFD/3", ok, r, c);
        end
    endtask

    task automatic test_wrap();
        logic [12:0] r; logic [7:0] c; int lat; bit ok;
        beat_q = '{13'h1FFF, 13'h0001};
        accumulate(1'b1, r, c, lat, ok);
        checks++;
        if (!ok || r !== 13'd0 || c !== 8'd2) begin
            errors++;
            $display("FAIL wrap_pair: ok=%b data=%h count=%0d, want 0/2", ok, r, c);
        end
        beat_q = '{13'h1000, 13'h1000, 13'h1000, 13'h1000};
        accumulate(1'b1, r, c, lat, ok);
        checks++;
        if (!ok || r !== 13'd0 || c !== 8'd4) begin
            errors++;
            $display("FAIL wrap_four: ok=%b data=%h count=%0d, want 0/4", ok, r, c);
        end
    endtask

    task automatic test_hold_done();
        logic [12:0] r; logic [7:0] c; int lat; bit ok;
        beat_q = '{13'd100, 13'd200};
        accumulate(1'b0, r, c, lat, ok);
        checks++;
        if (!ok || r !== 13'd300 || c !== 8'd2) begin
            errors++;
            $display("FAIL hold_result: ok=%b data=%0d count=%0d, want 300/2", ok, r, c);
        end
        // Offer a beat while the result is held; it must be ignored.
        in_valid = 1'b1;
        in_data  = 13'h0055;
        in_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 13'd300 || out_count !== 8'd2 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable cyc %0d: valid=%b data=%0d count=%0d in_ready=%b",
                         i, out_valid, out_data, out_count, in_ready);
            end
        end
        in_data   = 13'd7;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== 13'd300) begin
            errors++;
            $display("FAIL handshake_edge: valid=%b in_ready=%b busy=%b data=%0d, want 0/1/0/300",
                     out_valid, in_ready, busy, out_data);
        end
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL accept_after_handshake: busy=%b in_ready=%b, want 1/0", busy, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat >= 100 || out_data !== 13'd7 || out_count !== 8'd1) begin
            errors++;
            $display("FAIL post_handshake_beat: data=%0d count=%0d lat=%0d, want 7/1", out_data, out_count, lat);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_resolve();
        logic [12:0] r; logic [7:0] c; int lat; bit ok; bit a; bit seen;
        drive_beat(13'h0AAA, 1'b1, a);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (!a || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 13'd0 || out_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_resolve: ok=%b valid=%b busy=%b data=%h count=%0d, want 0/0/0/0",
                     a, out_valid, busy, out_data, out_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_no_output: out_valid rose after reset, want 0");
        end
        beat_q = '{13'd2, 13'd3};
        accumulate(1'b1, r, c, lat, ok);
        checks++;
        if (!ok || r !== 13'd5 || c !== 8'd2) begin
            errors++;
            $display("FAIL after_reset: ok=%b data=%0d count=%0d, want 5/2", ok, r, c);
        end
    endtask

    task automatic test_saturate();
        logic [12:0] r; logic [7:0] c; int lat; bit ok;
        beat_q = {};
        for (int i = 0; i < 300; i++) beat_q.push_back(13'd1);
        accumulate(1'b1, r, c, lat, ok);
        checks++;
        if (!ok || r !== 13'd300 || c !== 8'd255) begin
            errors++;
            $display("FAIL saturate: ok=%b data=%0d count=%0d, want 300/255", ok, r, c);
        end
    endtask

    task automatic test_triples();
        logic [12:0] r; logic [7:0] c; int lat; bit ok;
        logic [12:0] exp;
        bubbles_en = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int d = 0; d < 16; d++) begin
                    beat_q = '{13'(a), 13'(b), 13'(d)};
                    exp = 13'(a + b + d);
                    accumulate(1'b1, r, c, lat, ok);
                    checks++;
                    if (!ok || r !== exp || c !== 8'd3) begin
                        errors++;
                        $display("FAIL triple %0d+%0d+%0d: ok=%b data=%0d count=%0d, want %0d/3",
                                 a, b, d, ok, r, c, exp);
                    end
                end
            end
        end
        bubbles_en = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        bubbles_en = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        out_ready  = 1'b0;
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_wrap();
        test_hold_done();
        test_reset_resolve();
        test_saturate();
        test_triples();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
